ahb_sram_slave: RTL and testbench

//  AHB-Lite responder: word-organised SRAM on one slave port of the AHB node.

---
 rtl/ahb_sram_slave.sv | 190 +++++++++++++++++++
 tb/tb_ahb_sram_slave.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder with optional wait states, byte lanes,
// write->read forwarding and a two-cycle ERROR response.
//
// Ports:
//   hclk_i, hreset_i            clock, synchronous active-high reset
//   hsel_i, hadrr_i, htrans_i   address-phase select/address/transfer type
//   hwrite_i, hsize_i           direction and log2(bytes)
//   hburst_i, hprot_i,
//   hmastlock_i                 accepted and ignored
//   hready_i                    bus-wide HREADY
//   hwdata_i                    write data (data phase)
//   hreadyout_o, hresp_o        transfer done / OKAY(0) or ERROR(1)
//   hrdata_o                    read data (zero outside read data phases)
module ahb_sram_slave #(
    parameter int AHB_DATA_WIDTH = 32,
    parameter int AHB_ADDR_WIDTH = 32,
    parameter logic [AHB_ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int MEM_DEPTH = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                      hclk_i,
    input  logic                      hreset_i,
    input  logic                      hsel_i,
    input  logic [AHB_ADDR_WIDTH-1:0] hadrr_i,
    input  logic [1:0]                htrans_i,
    input  logic                      hwrite_i,
    input  logic [2:0]                hsize_i,
    input  logic [2:0]                hburst_i,
    input  logic [3:0]                hprot_i,
    input  logic                      hmastlock_i,
    input  logic                      hready_i,
    input  logic [AHB_DATA_WIDTH-1:0] hwdata_i,
    output logic                      hreadyout_o,
    output logic                      hresp_o,
    output logic [AHB_DATA_WIDTH-1:0] hrdata_o
);

    localparam int DW  = AHB_DATA_WIDTH;
    localparam int AW  = AHB_ADDR_WIDTH;
    localparam int NB  = DW / 8;
    localparam int LB  = $clog2(NB);
    localparam int LBW = (LB > 0) ? LB : 1;
    localparam int IW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [AW:0]   SPAN     = (AW+1)'(MEM_DEPTH * NB);
    localparam logic [2:0]    MAX_SIZE = 3'(LB);
    localparam logic [AW-1:0] LANE_MSK = AW'(NB - 1);
    localparam logic [3:0]    WS_INIT  =
        4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_OKAY,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            wr_q, rd_q;
    logic [IW-1:0]   widx_q;
    logic [NB-1:0]   wlane_q;
    logic [DW-1:0]   hold_q;

    logic [DW-1:0]   mem [MEM_DEPTH];

    logic            accept, legal, take, do_wr;
    logic [AW:0]     off;
    logic [AW-1:0]   amask;
    logic [IW-1:0]   idx;
    logic [LBW-1:0]  boff;
    logic [NB-1:0]   lanes_a;
    logic [DW-1:0]   mem_rd, merged;

    logic unused_ok;
    assign unused_ok = ^{hburst_i, hprot_i, hmastlock_i, htrans_i[0]};

    function automatic logic [NB-1:0] lane_mask(
        input logic [LBW-1:0] o,
        input logic [2:0]     s
    );
        logic [NB-1:0] m;
        m = '0;
        for (int b = 0; b < NB; b++)
            m[b] = (b >= int'(o)) && (b < int'(o) + (1 << s));
        return m;
    endfunction

    // Address-phase decode; the extra top bit of off catches addr < base.
    assign accept  = hsel_i & hready_i & htrans_i[1];
    assign off     = {1'b0, hadrr_i} - {1'b0, BASE_ADDR};
    assign amask   = AW'((32'd1 << hsize_i) - 32'd1);
    assign legal   = (hsize_i <= MAX_SIZE)
                   && ((hadrr_i & amask) == '0)
                   && !off[AW]
                   && (off < SPAN);
    assign idx     = IW'(off >> LB);
    assign boff    = LBW'(hadrr_i & LANE_MSK);
    assign lanes_a = lane_mask(boff, hsize_i);

    // Write commit happens in the last cycle of a write data phase.
    assign do_wr = (state_q == S_OKAY) && wr_q && !hreset_i;

    // Read fetch merges the lanes being written this very cycle.
    assign mem_rd = mem[idx];
    always_comb begin
        merged = mem_rd;
        if (do_wr && (widx_q == idx)) begin
            for (int b = 0; b < NB; b++)
                if (wlane_q[b])
                    merged[b*8 +: 8] = hwdata_i[b*8 +: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        take        = 1'b0;
        hreadyout_o = 1'b1;
        hresp_o     = 1'b0;
        case (state_q)
            S_WAIT: begin
                hreadyout_o = 1'b0;
                if (cnt_q == 4'd0)
                    state_d = S_OKAY;
                else
                    cnt_d = cnt_q - 4'd1;
            end
            S_ERR1: begin
                hreadyout_o = 1'b0;
                hresp_o     = 1'b1;
                state_d     = S_ERR2;
            end
            S_ERR2: begin
                hresp_o = 1'b1;
                take    = 1'b1;
            end
            default: take = 1'b1;
        endcase
        if (take) begin
            if (!accept)
                state_d = S_IDLE;
            else if (!legal)
                state_d = S_ERR1;
            else if (WAIT_STATES > 0) begin
                state_d = S_WAIT;
                cnt_d   = WS_INIT;
            end else
                state_d = S_OKAY;
        end
    end

    always_ff @(posedge hclk_i) begin
        if (hreset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            widx_q  <= '0;
            wlane_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (take) begin
                wr_q <= accept & legal & hwrite_i;
                rd_q <= accept & legal & ~hwrite_i;
                if (accept & legal) begin
                    widx_q  <= idx;
                    wlane_q <= lanes_a;
                    if (!hwrite_i)
                        hold_q <= merged;
                end
            end
        end
    end

    always_ff @(posedge hclk_i) begin
        if (do_wr) begin
            for (int b = 0; b < NB; b++)
                if (wlane_q[b])
                    mem[widx_q][b*8 +: 8] <= hwdata_i[b*8 +: 8];
        end
    end

    assign hrdata_o =
        (rd_q && (state_q == S_WAIT || state_q == S_OKAY)) ? hold_q : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: two responders (0 and 3 wait states) on a shared
// address/data bus, each selected in turn.
module tb_ahb_sram_slave;

    localparam logic [1:0] IDL = 2'b00;
    localparam logic [1:0] BSY = 2'b01;
    localparam logic [1:0] NS  = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel0, hsel1;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst = 3'd0;
    logic [3:0]  hprot = 4'd0;
    logic        hmastlock = 1'b0;
    logic [31:0] hwdata;
    logic        rdy_en;
    logic        hready0, hready1;
    logic        hro0, hresp0, hro1, hresp1;
    logic [31:0] hrd0, hrd1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign hready0 = hro0 & rdy_en;
    assign hready1 = hro1;

    ahb_sram_slave #(
        .BASE_ADDR(32'h0000_1000), .MEM_DEPTH(1024), .WAIT_STATES(0)
    ) u0 (
        .hclk_i(clk), .hreset_i(rst), .hsel_i(hsel0), .hadrr_i(haddr),
        .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize),
        .hburst_i(hburst), .hprot_i(hprot), .hmastlock_i(hmastlock),
        .hready_i(hready0), .hwdata_i(hwdata),
        .hreadyout_o(hro0), .hresp_o(hresp0), .hrdata_o(hrd0)
    );

    ahb_sram_slave #(
        .BASE_ADDR(32'h0000_1000), .MEM_DEPTH(1024), .WAIT_STATES(3)
    ) u1 (
        .hclk_i(clk), .hreset_i(rst), .hsel_i(hsel1), .hadrr_i(haddr),
        .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize),
        .hburst_i(hburst), .hprot_i(hprot), .hmastlock_i(hmastlock),
        .hready_i(hready1), .hwdata_i(hwdata),
        .hreadyout_o(hro1), .hresp_o(hresp1), .hrdata_o(hrd1)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic ap(logic s0, logic s1, logic [1:0] tr,
                      logic wr, logic [2:0] sz, logic [31:0] a);
        hsel0  = s0;
        hsel1  = s1;
        htrans = tr;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
    endtask

    task automatic idle();
        ap(1'b0, 1'b0, IDL, 1'b0, 3'd2, 32'h0);
    endtask

    task automatic st0(string t, logic r, logic e, logic [31:0] d);
        chk({t, ".rdy"},  {31'b0, hro0},   {31'b0, r});
        chk({t, ".resp"}, {31'b0, hresp0}, {31'b0, e});
        chk({t, ".data"}, hrd0, d);
    endtask

    task automatic st1(string t, logic r, logic e, logic [31:0] d);
        chk({t, ".rdy"},  {31'b0, hro1},   {31'b0, r});
        chk({t, ".resp"}, {31'b0, hresp1}, {31'b0, e});
        chk({t, ".data"}, hrd1, d);
    endtask

    task automatic wait1(string t);
        chk({t, ".rdy"},  {31'b0, hro1},   32'd0);
        chk({t, ".resp"}, {31'b0, hresp1}, 32'd0);
    endtask

    task automatic err0(string t);
        cyc();
        idle();
        st0({t, "_e1"}, 1'b0, 1'b1, 32'h0);
        cyc();
        st0({t, "_e2"}, 1'b1, 1'b1, 32'h0);
        cyc();
        st0({t, "_ok"}, 1'b1, 1'b0, 32'h0);
    endtask

    initial begin
        rst    = 1'b1;
        rdy_en = 1'b1;
        hwdata = 32'h0;
        idle();
        cyc();
        cyc();
        st0("reset0", 1'b1, 1'b0, 32'h0);
        st1("reset1", 1'b1, 1'b0, 32'h0);
        rst = 1'b0;

        // write then back-to-back read of the same word
        ap(1'b1, 1'b0, NS, 1'b1, 3'd2, 32'h1008);
        cyc();
        ap(1'b1, 1'b0, NS, 1'b0, 3'd2, 32'h1008);
        hwdata = 32'hDEAD_BEEF;
        st0("t1_wr", 1'b1, 1'b0, 32'h0);
        cyc();
        idle();
        st0("t1_rd", 1'b1, 1'b0, 32'hDEAD_BEEF);
        cyc();
        st0("t1_idle", 1'b1, 1'b0, 32'h0);

        // byte lane write with partial forwarding, then misaligned half
        ap(1'b1, 1'b0, NS, 1'b1, 3'd2, 32'h1000);
        cyc();
        hwdata = 32'h0;
        ap(1'b1, 1'b0, NS, 1'b1, 3'd0, 32'h1002);
        cyc();
        hwdata = 32'hFFA5_FFFF;
        ap(1'b1, 1'b0, NS, 1'b0, 3'd2, 32'h1000);
        cyc();
        idle();
        st0("t3_byte", 1'b1, 1'b0, 32'h00A5_0000);
        cyc();
        ap(1'b1, 1'b0, NS, 1'b1, 3'd1, 32'h1001);
        hwdata = 32'hFFFF_FFFF;
        err0("t3_half");
        ap(1'b1, 1'b0, NS, 1'b0, 3'd2, 32'h1000);
        cyc();
        idle();
        st0("t3_keep", 1'b1, 1'b0, 32'h00A5_0000);
        cyc();

        // range and size errors, plus the last legal word
        ap(1'b1, 1'b0, NS, 1'b0, 3'd2, 32'h2000);
        err0("t4_top");
        ap(1'b1, 1'b0, NS, 1'b0, 3'd3, 32'h1000);
        err0("t4_size");
        ap(1'b1, 1'b0, NS, 1'b0, 3'd2, 32'h0FFC);
        err0("t4_low");
        ap(1'b1, 1'b0, NS, 1'b1, 3'd2, 32'h1FFC);
        cyc();
        hwdata = 32'h1234_5678;
        idle();
        cyc();
        ap(1'b1, 1'b0, NS, 1'b0, 3'd2, 32'h1FFC);
        cyc();
        idle();
        st0("t4_last", 1'b1, 1'b0, 32'h1234_5678);
        cyc();

        // BUSY, deselected NONSEQ, and hready low: none start a transfer
        hwdata = 32'hFFFF_FFFF;
        ap(1'b1, 1'b0, BSY, 1'b1, 3'd2, 32'h1008);
        cyc();
        st0("t6_busy", 1'b1, 1'b0, 32'h0);
        ap(1'b0, 1'b0, NS, 1'b1, 3'd2, 32'h1008);
        cyc();
        st0("t6_nosel", 1'b1, 1'b0, 32'h0);
        rdy_en = 1'b0;
        ap(1'b1, 1'b0, NS, 1'b0, 3'd2, 32'h2000);
        cyc();
        st0("t6_nordy", 1'b1, 1'b0, 32'h0);
        rdy_en = 1'b1;
        ap(1'b1, 1'b0, NS, 1'b0, 3'd2, 32'h1008);
        cyc();
        idle();
        st0("t6_rd", 1'b1, 1'b0, 32'hDEAD_BEEF);
        cyc();

        // three wait states on write and read
        ap(1'b0, 1'b1, NS, 1'b1, 3'd2, 32'h1004);
        cyc();
        idle();
        hwdata = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            wait1("t2_wwait");
            cyc();
        end
        st1("t2_wok", 1'b1, 1'b0, 32'h0);
        cyc();
        ap(1'b0, 1'b1, NS, 1'b0, 3'd2, 32'h1004);
        cyc();
        idle();
        for (int i = 0; i < 3; i++) begin
            wait1("t2_rwait");
            cyc();
        end
        st1("t2_rok", 1'b1, 1'b0, 32'hCAFE_F00D);
        cyc();
        st1("t2_idle", 1'b1, 1'b0, 32'h0);

        // reset during a write wait drops the write
        ap(1'b0, 1'b1, NS, 1'b1, 3'd2, 32'h1004);
        cyc();
        idle();
        hwdata = 32'h1111_1111;
        wait1("t5_wait");
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        st1("t5_after", 1'b1, 1'b0, 32'h0);
        ap(1'b0, 1'b1, NS, 1'b0, 3'd2, 32'h1004);
        cyc();
        idle();
        for (int i = 0; i < 3; i++)
            cyc();
        st1("t5_keep", 1'b1, 1'b0, 32'hCAFE_F00D);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
